// File: rtl/posit_decoded_mul_pkg.sv
// Shared types for the decoded-posit multiplier and its bus interface.
package posit_mul_pkg;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } sign_t;

endpackage

// File: rtl/posit_decoded_mul_if.sv
// Operand/result bus of the decoded-posit multiplier.
// The slave modport is the multiplier; the master modport is the environment
// that supplies decoded operands and consumes the product fields.
interface posit_decoded_mul_if #(
    parameter int SCALE_W = 10
);
    import posit_mul_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    sign_t                     a_sign;
    sign_t                     b_sign;
    logic signed [7:0]         a_regime;
    logic signed [7:0]         b_regime;
    logic signed [7:0]         a_exponent;
    logic signed [7:0]         b_exponent;
    logic [7:0]                a_mantissa;
    logic [7:0]                b_mantissa;
    logic                      a_zero;
    logic                      b_zero;
    logic                      a_nar;
    logic                      b_nar;

    logic                      out_valid;
    logic                      out_ready;
    sign_t                     out_sign;
    logic signed [SCALE_W-1:0] out_scale;
    logic [7:0]                out_mantissa;
    logic                      out_guard;
    logic                      out_sticky;
    logic                      out_zero;
    logic                      out_nar;

    modport master (
        output in_valid, a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
               a_mantissa, b_mantissa, a_zero, b_zero, a_nar, b_nar, out_ready,
        input  in_ready, out_valid, out_sign, out_scale, out_mantissa,
               out_guard, out_sticky, out_zero, out_nar
    );

    modport slave (
        input  in_valid, a_sign, b_sign, a_regime, b_regime, a_exponent, b_exponent,
               a_mantissa, b_mantissa, a_zero, b_zero, a_nar, b_nar, out_ready,
        output in_ready, out_valid, out_sign, out_scale, out_mantissa,
               out_guard, out_sticky, out_zero, out_nar
    );

endinterface

// File: rtl/posit_decoded_mul.sv
// Two-stage multiplier on decoded posit fields (sign, regime, exponent, Q1.7
// mantissa). Stage 1 forms the sign, the summed scale and the raw Q2.14
// product; stage 2 normalises the product to Q1.7 and applies NaR/zero.
// Optional feature macro: POSIT_MUL_STICKY_EN -- when defined, guard and sticky
// bits are produced from the product bits below the mantissa; otherwise those
// bits are never formed and out_guard/out_sticky are tied low.
module posit_decoded_mul
    import posit_mul_pkg::*;
#(
    parameter int EN      = 1,
    parameter int SCALE_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    posit_decoded_mul_if.slave bus
);

`ifdef POSIT_MUL_STICKY_EN
    localparam int PROD_LSB = 0;
`else
    localparam int PROD_LSB = 7;
`endif

    logic                      s1_valid;
    sign_t                     s1_sign;
    logic signed [SCALE_W-1:0] s1_scale;
    logic [15:PROD_LSB]        s1_prod;
    logic                      s1_zero;
    logic                      s1_nar;
    logic                      s2_valid;
    logic                      s2_free;

    logic signed [SCALE_W-1:0] sa;
    logic signed [SCALE_W-1:0] sb;
    logic [15:PROD_LSB]        prod_c;
    logic                      nar_c;

    sign_t                     n_sign;
    logic signed [SCALE_W-1:0] n_scale;
    logic [7:0]                n_mant;
`ifdef POSIT_MUL_STICKY_EN
    logic                      n_guard;
    logic                      n_sticky;
`endif

    assign s2_free      = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s2_free;
    assign bus.out_valid = s2_valid;

    // Operand scales: regime weighted by 2^EN plus the exponent, sign-extended.
    assign sa    = (SCALE_W'(bus.a_regime) <<< EN) + SCALE_W'(bus.a_exponent);
    assign sb    = (SCALE_W'(bus.b_regime) <<< EN) + SCALE_W'(bus.b_exponent);
    assign nar_c = bus.a_nar | bus.b_nar;

`ifdef POSIT_MUL_STICKY_EN
    assign prod_c = 16'(bus.a_mantissa) * 16'(bus.b_mantissa);
`else
    // Only the bits that can land in the mantissa are kept.
    assign prod_c = 9'((16'(bus.a_mantissa) * 16'(bus.b_mantissa)) >> 7);
`endif

    // Stage 1: capture the combined sign, scale sum, raw product and special flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= POS;
            s1_scale <= '0;
            s1_prod  <= '0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign  <= sign_t'(bus.a_sign ^ bus.b_sign);
                s1_scale <= sa + sb;
                s1_prod  <= prod_c;
                s1_nar   <= nar_c;
                s1_zero  <= (bus.a_zero | bus.b_zero) & ~nar_c;
            end
        end
    end

    // Normalise Q2.14 to Q1.7 (bumping the scale when the product is >= 2), then
    // clear the numeric fields for NaR/zero; NaR also forces a positive sign.
    always_comb begin
        n_sign  = s1_sign;
        n_scale = s1_scale;
        n_mant  = s1_prod[14:7];
        if (s1_prod[15]) begin
            n_mant  = s1_prod[15:8];
            n_scale = s1_scale + SCALE_W'(1);
        end
`ifdef POSIT_MUL_STICKY_EN
        if (s1_prod[15]) begin
            n_guard  = s1_prod[7];
            n_sticky = |s1_prod[6:0];
        end else begin
            n_guard  = s1_prod[6];
            n_sticky = |s1_prod[5:0];
        end
`endif
        if (s1_nar | s1_zero) begin
            n_mant  = '0;
            n_scale = '0;
`ifdef POSIT_MUL_STICKY_EN
            n_guard  = 1'b0;
            n_sticky = 1'b0;
`endif
        end
        if (s1_nar) begin
            n_sign = POS;
        end
    end

    // Stage 2: result register, held while the downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid         <= 1'b0;
            bus.out_sign     <= POS;
            bus.out_scale    <= '0;
            bus.out_mantissa <= '0;
            bus.out_zero     <= 1'b0;
            bus.out_nar      <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sign     <= n_sign;
                bus.out_scale    <= n_scale;
                bus.out_mantissa <= n_mant;
                bus.out_zero     <= s1_zero;
                bus.out_nar      <= s1_nar;
            end
        end
    end

`ifdef POSIT_MUL_STICKY_EN
    // Rounding bits travel alongside the stage-2 result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_guard  <= 1'b0;
            bus.out_sticky <= 1'b0;
        end else if (s2_free && s1_valid) begin
            bus.out_guard  <= n_guard;
            bus.out_sticky <= n_sticky;
        end
    end
`else
    assign bus.out_guard  = 1'b0;
    assign bus.out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_posit_decoded_mul.sv
// Directed self-checking bench for posit_decoded_mul (EN = 1, SCALE_W = 10).
module tb_posit_decoded_mul;
    import posit_mul_pkg::*;

    localparam int EN      = 1;
    localparam int SCALE_W = 10;
    localparam int RES_W   = 1 + SCALE_W + 8 + 4;
`ifdef POSIT_MUL_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct {
        sign_t             a_s;
        logic signed [7:0] a_r;
        logic signed [7:0] a_e;
        logic [7:0]        a_m;
        logic              a_z;
        logic              a_n;
        sign_t             b_s;
        logic signed [7:0] b_r;
        logic signed [7:0] b_e;
        logic [7:0]        b_m;
        logic              b_z;
        logic              b_n;
        logic [RES_W-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    posit_decoded_mul_if #(.SCALE_W(SCALE_W)) bus ();

    posit_decoded_mul #(.EN(EN), .SCALE_W(SCALE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [RES_W-1:0] mk(logic s, int sc, logic [7:0] m,
                                            logic g, logic st, logic z, logic n);
        return {s, SCALE_W'(sc), m, g & STK, st & STK, z, n};
    endfunction

    function automatic logic [RES_W-1:0] res_now();
        return {bus.out_sign, bus.out_scale, bus.out_mantissa,
                bus.out_guard, bus.out_sticky, bus.out_zero, bus.out_nar};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input vec_t v);
        bus.a_sign     = v.a_s;
        bus.a_regime   = v.a_r;
        bus.a_exponent = v.a_e;
        bus.a_mantissa = v.a_m;
        bus.a_zero     = v.a_z;
        bus.a_nar      = v.a_n;
        bus.b_sign     = v.b_s;
        bus.b_regime   = v.b_r;
        bus.b_exponent = v.b_e;
        bus.b_mantissa = v.b_m;
        bus.b_zero     = v.b_z;
        bus.b_nar      = v.b_n;
    endtask

    function automatic vec_t simple(logic signed [7:0] a_r, logic signed [7:0] b_r);
        vec_t v;
        v = '{POS, a_r, 8'sd0, 8'h80, 1'b0, 1'b0, POS, b_r, 8'sd0, 8'h80, 1'b0, 1'b0, '0};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #22;
        total++;
        if (bus.out_valid !== 1'b0 || res_now() !== mk(0, 0, 8'h00, 0, 0, 0, 0))
            $display("FAIL reset_state: valid=%b res=%h required valid=0 res=0", bus.out_valid, res_now());
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        else passed++;
    endtask

    task automatic test_vectors();
        vec_t v[8];
        v[0] = '{POS, 8'sd0, 8'sd0, 8'h80, 1'b0, 1'b0, POS, 8'sd0, 8'sd0, 8'h80, 1'b0, 1'b0,
                 mk(0, 0, 8'h80, 0, 0, 0, 0)};
        v[1] = '{POS, 8'sd0, 8'sd0, 8'hC0, 1'b0, 1'b0, POS, 8'sd0, 8'sd0, 8'hC0, 1'b0, 1'b0,
                 mk(0, 1, 8'h90, 0, 0, 0, 0)};
        v[2] = '{NEG, 8'sd1, 8'sd1, 8'hA0, 1'b0, 1'b0, POS, -8'sd2, 8'sd0, 8'h80, 1'b0, 1'b0,
                 mk(1, -1, 8'hA0, 0, 0, 0, 0)};
        v[3] = '{POS, 8'sd3, 8'sd1, 8'hC1, 1'b0, 1'b0, NEG, -8'sd1, 8'sd0, 8'h81, 1'b0, 1'b0,
                 mk(1, 5, 8'hC2, 1, 1, 0, 0)};
        v[4] = '{POS, 8'sd127, 8'sd1, 8'hFF, 1'b0, 1'b0, POS, 8'sd127, 8'sd1, 8'hFF, 1'b0, 1'b0,
                 mk(0, 511, 8'hFE, 0, 1, 0, 0)};
        v[5] = '{POS, -8'sd128, 8'sd0, 8'h80, 1'b0, 1'b0, POS, -8'sd128, 8'sd0, 8'h80, 1'b0, 1'b0,
                 mk(0, -512, 8'h80, 0, 0, 0, 0)};
        v[6] = '{NEG, 8'sd2, 8'sd1, 8'hA0, 1'b0, 1'b1, POS, 8'sd0, 8'sd0, 8'h80, 1'b1, 1'b0,
                 mk(0, 0, 8'h00, 0, 0, 0, 1)};
        v[7] = '{POS, 8'sd5, 8'sd0, 8'h80, 1'b1, 1'b0, NEG, 8'sd3, 8'sd1, 8'hC0, 1'b0, 1'b0,
                 mk(1, 0, 8'h00, 0, 0, 1, 0)};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_ops(v[i]);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            total++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL vec%0d_early_valid: got %b required 0", i, bus.out_valid);
            else passed++;
            tick();
            total++;
            if (bus.out_valid !== 1'b1)
                $display("FAIL vec%0d_valid: got %b required 1", i, bus.out_valid);
            else passed++;
            total++;
            if (res_now() !== v[i].exp)
                $display("FAIL vec%0d_result: got %h required %h", i, res_now(), v[i].exp);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                set_ops(simple(8'(10 * (c + 1)), 8'sd0));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c >= 2) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_scale !== SCALE_W'(20 * (c - 1)))
                    $display("FAIL b2b_%0d: valid=%b scale=%0d required valid=1 scale=%0d",
                             c, bus.out_valid, bus.out_scale, 20 * (c - 1));
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_stall_stream();
        int               sent = 0;
        int               got  = 0;
        bit               saw_block = 1'b0;
        bit               stalled_prev = 1'b0;
        logic [RES_W-1:0] held = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            bus.out_ready = !(c >= 3 && c <= 5);
            if (sent < 4) begin
                set_ops(simple(8'(sent + 1), 8'sd0));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                total++;
                if (bus.out_valid !== 1'b1 || res_now() !== held)
                    $display("FAIL stall_hold_%0d: valid=%b res=%h required valid=1 res=%h",
                             c, bus.out_valid, res_now(), held);
                else passed++;
            end
            if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (bus.out_scale !== SCALE_W'(2 * (got + 1)))
                    $display("FAIL stream_order_%0d: scale=%0d required %0d",
                             got, bus.out_scale, 2 * (got + 1));
                else passed++;
                got++;
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held = res_now();
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++;
        if (got !== 4) $display("FAIL stream_count: got %0d results required 4", got);
        else passed++;
        total++;
        if (saw_block !== 1'b1) $display("FAIL stream_backpressure: in_ready never dropped, required a drop");
        else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL stream_no_dup: out_valid=%b required 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_ops(simple(8'(40 + i), 8'sd0));
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1)
            $display("FAIL midrst_full: out_valid=%b required 1", bus.out_valid);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL midrst_async: out_valid=%b required 0", bus.out_valid);
        else passed++;
        #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        set_ops(simple(8'sd5, 8'sd0));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8 && !bus.out_valid; i++) tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_scale !== SCALE_W'(10))
            $display("FAIL midrst_first: valid=%b scale=%0d required valid=1 scale=10",
                     bus.out_valid, bus.out_scale);
        else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL midrst_stale: out_valid=%b required 0", bus.out_valid);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_ops(simple(8'sd0, 8'sd0));
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall_stream();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
